store_queue_ctrl: RTL and testbench

Parametrised store unit between the pipeline's memory stage and the DMEM/IMEM/IO write ports. It converts RISC-V stores (SB/SH/SW, plus SD when DATA_W=64) into lane-aligned data and per-destination byte write-enables. It buffers stores in a DEPTH-entry FIFO drained over a valid/ready handshake. It also flags misaligned or invalid stores, and reports pending-store address hits so the load path can stall.

---
 rtl/store_queue_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_store_queue_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue_ctrl.sv
// Store unit: decodes SB/SH/SW(/SD) into lane-aligned data and per-destination byte enables,
// buffers them in a small FIFO, and reports pending-store word hits for the load path.
module store_queue_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_funct3,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  input  logic [31:0]                req_pc,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        dmem_wea,
  output logic [DATA_W/8-1:0]        imem_wea,
  output logic [DATA_W/8-1:0]        io_wea,
  output logic                       err_misalign,
  output logic                       err_illegal,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [ADDR_W-1:0]          chk_addr,
  output logic                       chk_hit
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned OB = $clog2(NB);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Request decode
  logic [7:0]        lanes8;
  logic [2:0]        align_low;
  logic              legal_f3;
  logic [OB-1:0]     off;
  logic [2:0]        off3;
  logic [NB-1:0]     size_mask;
  logic [NB-1:0]     byte_mask;
  logic [DATA_W-1:0] data_masked;
  logic [DATA_W-1:0] wdata_new;
  logic [ADDR_W-1:0] addr_new;
  logic [3:0]        region;
  logic              is_mem_region;
  logic              mapped;
  logic              misaligned;
  logic [NB-1:0]     dmem_new;
  logic [NB-1:0]     imem_new;
  logic [NB-1:0]     io_new;

  always_comb begin
    lanes8    = 8'h00;
    align_low = 3'd0;
    legal_f3  = 1'b1;
    case (req_funct3)
      3'b000: begin lanes8 = 8'h01; align_low = 3'd0; end
      3'b001: begin lanes8 = 8'h03; align_low = 3'd1; end
      3'b010: begin lanes8 = 8'h0f; align_low = 3'd3; end
      3'b011: begin
        if (DATA_W == 64) begin
          lanes8    = 8'hff;
          align_low = 3'd7;
        end else begin
          legal_f3 = 1'b0;
        end
      end
      default: legal_f3 = 1'b0;
    endcase
  end

  assign off       = req_addr[OB-1:0];
  assign off3      = 3'(off);
  assign size_mask = lanes8[NB-1:0];
  assign byte_mask = size_mask << off;
  assign misaligned = (off3 & align_low) != 3'd0;

  always_comb begin
    data_masked = '0;
    for (int i = 0; i < int'(NB); i++) begin
      data_masked[8*i +: 8] = size_mask[i] ? req_data[8*i +: 8] : 8'h00;
    end
  end

  assign wdata_new = data_masked << {off, 3'b000};
  assign addr_new  = {req_addr[ADDR_W-1:OB], {OB{1'b0}}};

  assign region        = req_addr[31:28];
  assign is_mem_region = (region == 4'b0001) || (region == 4'b0010) || (region == 4'b0011);
  assign mapped        = is_mem_region || (region == 4'b1000);
  assign dmem_new      = (is_mem_region && region[0]) ? byte_mask : '0;
  assign imem_new      = (is_mem_region && region[1] && req_pc[30]) ? byte_mask : '0;
  assign io_new        = (region == 4'b1000) ? byte_mask : '0;

  // Queue control
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_misalign_q, err_misalign_d;
  logic          err_illegal_q, err_illegal_d;
  logic          accept, push, pop;

  assign req_ready = (count_q != CW'(DEPTH));
  assign mem_valid = (count_q != '0);
  assign accept    = req_valid && req_ready;
  assign push      = accept && legal_f3 && mapped && !misaligned;
  assign pop       = mem_valid && mem_ready;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    err_illegal_d  = accept && (!legal_f3 || !mapped);
    err_misalign_d = accept && legal_f3 && mapped && misaligned;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      err_misalign_q <= 1'b0;
      err_illegal_q  <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      err_misalign_q <= err_misalign_d;
      err_illegal_q  <= err_illegal_d;
    end
  end

  // Entry storage needs no reset: it is only observed through occupied slots.
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [NB-1:0]     dwea_q  [DEPTH];
  logic [NB-1:0]     iwea_q  [DEPTH];
  logic [NB-1:0]     owea_q  [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q]  <= addr_new;
      wdata_q[wr_ptr_q] <= wdata_new;
      dwea_q[wr_ptr_q]  <= dmem_new;
      iwea_q[wr_ptr_q]  <= imem_new;
      owea_q[wr_ptr_q]  <= io_new;
    end
  end

  assign mem_addr     = mem_valid ? addr_q[rd_ptr_q]  : '0;
  assign mem_wdata    = mem_valid ? wdata_q[rd_ptr_q] : '0;
  assign dmem_wea     = mem_valid ? dwea_q[rd_ptr_q]  : '0;
  assign imem_wea     = mem_valid ? iwea_q[rd_ptr_q]  : '0;
  assign io_wea       = mem_valid ? owea_q[rd_ptr_q]  : '0;
  assign err_misalign = err_misalign_q;
  assign err_illegal  = err_illegal_q;
  assign count        = count_q;

  // A slot is occupied when its distance from the read pointer is below the count.
  logic [PW-1:0] rel;
  always_comb begin
    chk_hit = 1'b0;
    rel     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rel = PW'(i) - rd_ptr_q;
      if (({1'b0, rel} < count_q) && (addr_q[i][ADDR_W-1:OB] == chk_addr[ADDR_W-1:OB])) begin
        chk_hit = 1'b1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{req_pc[31], req_pc[29:0], chk_addr[OB-1:0]};

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Directed bench for store_queue_ctrl: a 32-bit instance for decode/queue behaviour and a
// 64-bit instance for SD lanes and reset with stores pending.
module tb_store_queue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 32-bit instance
  logic        rst, req_valid, req_ready, mem_valid, mem_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_data, req_pc, mem_addr, mem_wdata, chk_addr;
  logic [3:0]  dmem_wea, imem_wea, io_wea;
  logic        err_misalign, err_illegal, chk_hit;
  logic [2:0]  count;

  store_queue_ctrl #(.DATA_W(32), .DEPTH(4), .ADDR_W(32)) u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_pc       (req_pc),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .dmem_wea     (dmem_wea),
    .imem_wea     (imem_wea),
    .io_wea       (io_wea),
    .err_misalign (err_misalign),
    .err_illegal  (err_illegal),
    .count        (count),
    .chk_addr     (chk_addr),
    .chk_hit      (chk_hit)
  );

  // 64-bit instance
  logic        s_rst, s_req_valid, s_req_ready, s_mem_valid, s_mem_ready;
  logic [2:0]  s_req_funct3;
  logic [31:0] s_req_addr, s_req_pc, s_mem_addr, s_chk_addr;
  logic [63:0] s_req_data, s_mem_wdata;
  logic [7:0]  s_dmem_wea, s_imem_wea, s_io_wea;
  logic        s_err_misalign, s_err_illegal, s_chk_hit;
  logic [2:0]  s_count;

  store_queue_ctrl #(.DATA_W(64), .DEPTH(4), .ADDR_W(32)) u_dut64 (
    .clk          (clk),
    .rst          (s_rst),
    .req_valid    (s_req_valid),
    .req_ready    (s_req_ready),
    .req_funct3   (s_req_funct3),
    .req_addr     (s_req_addr),
    .req_data     (s_req_data),
    .req_pc       (s_req_pc),
    .mem_valid    (s_mem_valid),
    .mem_ready    (s_mem_ready),
    .mem_addr     (s_mem_addr),
    .mem_wdata    (s_mem_wdata),
    .dmem_wea     (s_dmem_wea),
    .imem_wea     (s_imem_wea),
    .io_wea       (s_io_wea),
    .err_misalign (s_err_misalign),
    .err_illegal  (s_err_illegal),
    .count        (s_count),
    .chk_addr     (s_chk_addr),
    .chk_hit      (s_chk_hit)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] pc);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_addr   = a;
    req_data   = d;
    req_pc     = pc;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic push64(input logic [2:0] f3, input logic [31:0] a, input logic [63:0] d);
    s_req_valid  = 1'b1;
    s_req_funct3 = f3;
    s_req_addr   = a;
    s_req_data   = d;
    tick();
    s_req_valid  = 1'b0;
  endtask

  logic [31:0] exp_addr [4];

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b1; req_funct3 = 3'b010;
    req_addr = '0; req_data = '0; req_pc = '0; chk_addr = '0;
    s_rst = 1'b1; s_req_valid = 1'b0; s_mem_ready = 1'b0; s_req_funct3 = 3'b011;
    s_req_addr = '0; s_req_data = '0; s_req_pc = '0; s_chk_addr = '0;
    tick();
    tick();
    rst   = 1'b0;
    s_rst = 1'b0;

    check("rst_count", 64'(count), 0);
    check("rst_valid", 64'(mem_valid), 0);
    check("rst_ready", 64'(req_ready), 1);
    check("rst_addr", 64'(mem_addr), 0);
    check("rst_wdata", 64'(mem_wdata), 0);
    check("rst_wea", 64'({dmem_wea, imem_wea, io_wea}), 0);
    check("rst_err", 64'({err_misalign, err_illegal}), 0);

    // SW to DMEM
    chk_addr = 32'h1000_0006;
    push32(3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0);
    check("sw_valid", 64'(mem_valid), 1);
    check("sw_addr", 64'(mem_addr), 64'h1000_0004);
    check("sw_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    check("sw_dwea", 64'(dmem_wea), 4'b1111);
    check("sw_iwea", 64'(imem_wea), 0);
    check("sw_count", 64'(count), 1);
    check("sw_hit", 64'(chk_hit), 1);
    tick();
    check("sw_popped", 64'(count), 0);
    check("sw_hit_gone", 64'(chk_hit), 0);

    // SB to DMEM+IMEM
    push32(3'b000, 32'h3000_0003, 32'h0000_00A5, 32'h4000_0000);
    check("sb_wdata", 64'(mem_wdata), 64'hA500_0000);
    check("sb_addr", 64'(mem_addr), 64'h3000_0000);
    check("sb_dwea", 64'(dmem_wea), 4'b1000);
    check("sb_iwea", 64'(imem_wea), 4'b1000);
    check("sb_iowea", 64'(io_wea), 0);
    tick();

    // SH to IO, upper half
    push32(3'b001, 32'h8000_0002, 32'h1234_BEEF, 32'h0);
    check("sh_io_wdata", 64'(mem_wdata), 64'hBEEF_0000);
    check("sh_io_wea", 64'(io_wea), 4'b1100);
    check("sh_io_dwea", 64'(dmem_wea), 0);
    tick();

    // Error cases
    push32(3'b001, 32'h1000_0001, 32'h0000_1234, 32'h0);
    check("mis_pulse", 64'(err_misalign), 1);
    check("mis_ill", 64'(err_illegal), 0);
    check("mis_count", 64'(count), 0);
    check("mis_valid", 64'(mem_valid), 0);
    tick();
    check("mis_pulse_end", 64'(err_misalign), 0);
    push32(3'b100, 32'h1000_0000, 32'h0, 32'h0);
    check("f3_illegal", 64'(err_illegal), 1);
    check("f3_count", 64'(count), 0);
    push32(3'b011, 32'h1000_0000, 32'h0, 32'h0);
    check("sd32_illegal", 64'(err_illegal), 1);
    push32(3'b010, 32'h5000_0000, 32'h0, 32'h0);
    check("reg_illegal", 64'(err_illegal), 1);
    check("reg_mis", 64'(err_misalign), 0);
    check("reg_count", 64'(count), 0);
    tick();
    check("ill_pulse_end", 64'(err_illegal), 0);

    // IMEM-only store without pc[30] still occupies a slot
    push32(3'b010, 32'h2000_0000, 32'h1111_2222, 32'h0);
    check("imem_only_count", 64'(count), 1);
    check("imem_only_wea", 64'({dmem_wea, imem_wea, io_wea}), 0);
    tick();
    check("imem_only_drain", 64'(count), 0);

    // Fill, pending-hit, full, ordered drain
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_addr[i] = 32'h1000_0010 + 32'(4 * i);
      push32(3'b010, exp_addr[i], 32'hA0 + 32'(i), 32'h0);
      if (i == 0) begin
        chk_addr = 32'h1000_0012;
        #1;
        check("hit_same_word", 64'(chk_hit), 1);
        chk_addr = 32'h1000_0014;
        #1;
        check("miss_next_word", 64'(chk_hit), 0);
      end
    end
    check("full_count", 64'(count), 4);
    check("full_ready", 64'(req_ready), 0);
    chk_addr = 32'h1000_001E;
    #1;
    check("hit_last", 64'(chk_hit), 1);
    check("head_addr0", 64'(mem_addr), 64'(exp_addr[0]));
    check("head_data0", 64'(mem_wdata), 64'hA0);
    mem_ready = 1'b1;
    push32(3'b010, 32'h1000_0020, 32'hFF, 32'h0);
    check("full_no_accept", 64'(count), 3);
    for (int i = 1; i < 4; i++) begin
      check("drain_addr", 64'(mem_addr), 64'(exp_addr[i]));
      check("drain_data", 64'(mem_wdata), 64'hA0 + 64'(i));
      tick();
    end
    check("drain_empty", 64'(count), 0);
    check("drain_valid", 64'(mem_valid), 0);
    chk_addr = 32'h1000_0012;
    #1;
    check("drain_nohit", 64'(chk_hit), 0);

    // Simultaneous push/pop across pointer wrap
    for (int i = 0; i < 3; i++) begin
      push32(3'b010, 32'h1000_0040 + 32'(4 * i), 32'hC0 + 32'(i), 32'h0);
      check("wrap_count", 64'(count), 1);
      check("wrap_addr", 64'(mem_addr), 64'h1000_0040 + 64'(4 * i));
      check("wrap_data", 64'(mem_wdata), 64'hC0 + 64'(i));
    end
    tick();
    check("wrap_empty", 64'(count), 0);

    // 64-bit: SD, then reset with two pending entries
    push64(3'b011, 32'h1000_0008, 64'h1122_3344_5566_7788);
    check("sd_addr", 64'(s_mem_addr), 64'h1000_0008);
    check("sd_wdata", s_mem_wdata, 64'h1122_3344_5566_7788);
    check("sd_dwea", 64'(s_dmem_wea), 8'hFF);
    push64(3'b010, 32'h1000_000C, 64'h0000_0000_CAFE_F00D);
    check("sd_count2", 64'(s_count), 2);
    check("sd_head_stable", s_mem_wdata, 64'h1122_3344_5566_7788);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    check("rst64_count", 64'(s_count), 0);
    check("rst64_valid", 64'(s_mem_valid), 0);
    check("rst64_wea", 64'(s_dmem_wea), 0);
    check("rst64_wdata", s_mem_wdata, 0);
    s_mem_ready = 1'b1;
    push64(3'b010, 32'h1000_000C, 64'h0000_0000_CAFE_F00D);
    check("sw64_addr", 64'(s_mem_addr), 64'h1000_0008);
    check("sw64_wdata", s_mem_wdata, 64'hCAFE_F00D_0000_0000);
    check("sw64_dwea", 64'(s_dmem_wea), 8'hF0);
    tick();
    check("sw64_empty", 64'(s_count), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
